axi4_mem_slave: RTL

- Parametrised AXI4 memory slave; successor to the fixed 64-bit testbench memory model.
- Behaviourally complete for FIXED, INCR and WRAP bursts, with WSTRB byte enables and correct byte-lane placement.
- Flags illegal or out-of-range accesses with SLVERR.
- Sits in the ENV as the DUT-side memory target for the UVM AXI master agent; one outstanding write and one outstanding read, handled by independent FSMs.

---
 rtl/axi4_mem_pkg.sv | 25 ++
 rtl/axi4_burst_addr.sv | 64 ++++++
 rtl/axi4_mem_slave.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_mem_pkg.sv
// axi4_mem_pkg: burst/response encodings and FSM state types shared by the
// axi4_mem_slave block and its address calculator.
package axi4_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

endpackage

// File: rtl/axi4_burst_addr.sv
// axi4_burst_addr: per-beat address arithmetic for one AXI channel -- next beat
// address, active byte lanes, size/WRAP legality and out-of-range detection.
module axi4_burst_addr
    import axi4_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic [7:0]          len,
    input  logic [2:0]          size,
    input  logic [1:0]          burst,
    output logic [ADDR_W-1:0]   next_addr,
    output logic [ADDR_W-1:0]   base_addr,
    output logic [DATA_W/8-1:0] lane_mask,
    output logic                legal,
    output logic                out_of_range
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LB = $clog2(NB);

    burst_e            btype;
    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] total;
    logic [ADDR_W-1:0] lower;
    logic [LB-1:0]     lane_lo;
    logic [LB-1:0]     lane_hi;
    logic              size_ok;
    logic              wrap_ok;

    always_comb begin
        btype   = burst_e'(burst);
        bytes   = ADDR_W'(1) << size;
        aligned = addr & ~(bytes - ADDR_W'(1));
        incr    = aligned + bytes;
        total   = bytes * (ADDR_W'(len) + ADDR_W'(1));
        lower   = addr & ~(total - ADDR_W'(1));

        size_ok = (size <= 3'(LB));
        wrap_ok = (btype != BURST_WRAP) || (len inside {8'd1, 8'd3, 8'd7, 8'd15});
        legal   = size_ok && wrap_ok;

        case (btype)
            BURST_INCR: next_addr = incr;
            BURST_WRAP: next_addr = (incr == lower + total) ? lower : incr;
            default:    next_addr = addr;
        endcase

        // Unaligned first beat only covers addr up to the next size boundary.
        base_addr = addr & ~ADDR_W'(NB - 1);
        lane_lo   = addr[LB-1:0];
        lane_hi   = aligned[LB-1:0] + LB'(bytes - ADDR_W'(1));
        lane_mask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            lane_mask[i] = (LB'(i) >= lane_lo) && (LB'(i) <= lane_hi);
        end

        out_of_range = (incr - ADDR_W'(1)) >= ADDR_W'(MEM_BYTES);
    end

endmodule

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 byte-addressed memory slave, one outstanding write and read.
// Define AXI4_MEM_RD_PIPE_EN for an extra R register stage with a 2-entry skid.
module axi4_mem_slave
    import axi4_mem_pkg::*;
#(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned MI = $clog2(MEM_BYTES);

    logic [7:0] mem [MEM_BYTES];

    // Write channel
    wstate_e           wstate, wstate_n;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic [8:0]        w_cnt;
    logic              w_err;
    logic [ADDR_W-1:0] w_next, w_base;
    logic [NB-1:0]     w_mask;
    logic              w_legal, w_oob;

    axi4_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) u_waddr (
        .addr(w_addr), .len(aw_len), .size(aw_size), .burst(aw_burst),
        .next_addr(w_next), .base_addr(w_base), .lane_mask(w_mask),
        .legal(w_legal), .out_of_range(w_oob)
    );

    always_comb begin
        wstate_n = wstate;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        bid      = '0;
        bresp    = OKAY;
        case (wstate)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) wstate_n = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) wstate_n = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bid    = aw_id;
                bresp  = w_err ? SLVERR : OKAY;
                if (bready) wstate_n = W_IDLE;
            end
            default: wstate_n = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arst) begin
            wstate   <= W_IDLE;
            aw_id    <= '0;
            w_addr   <= '0;
            aw_len   <= '0;
            aw_size  <= '0;
            aw_burst <= '0;
            w_cnt    <= '0;
            w_err    <= 1'b0;
        end else begin
            wstate <= wstate_n;
            if (awvalid && awready) begin
                aw_id    <= awid;
                w_addr   <= awaddr;
                aw_len   <= awlen;
                aw_size  <= awsize;
                aw_burst <= awburst;
                w_cnt    <= '0;
                w_err    <= 1'b0;
            end
            if (wvalid && wready) begin
                w_addr <= w_next;
                w_cnt  <= w_cnt + 9'd1;
                if (!w_legal || w_oob || (wlast && (w_cnt != {1'b0, aw_len})))
                    w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (arst && wvalid && wready && w_legal) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (w_mask[i] && wstrb[i] && ((w_base + ADDR_W'(i)) < ADDR_W'(MEM_BYTES)))
                    mem[MI'(w_base + ADDR_W'(i))] <= wdata[8*i +: 8];
            end
        end
    end

    // Read channel
    rstate_e           rstate, rstate_n;
    logic [ID_W-1:0]   ar_id;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_idx;
    logic [ADDR_W-1:0] ra_addr;
    logic [7:0]        ra_len;
    logic [2:0]        ra_size;
    logic [1:0]        ra_burst;
    logic [ADDR_W-1:0] r_next, r_base;
    logic [NB-1:0]     r_mask;
    logic              r_legal, r_oob;
    logic [DATA_W-1:0] rd_beat;
    logic              r_first, r_load, r_done;
    logic              p_valid, p_last, p_ready;
    logic [ID_W-1:0]   p_id;
    logic [DATA_W-1:0] p_data;
    logic [1:0]        p_resp;

    // Idle evaluates the incoming AR so beat 0 loads on the handshake edge.
    assign ra_addr  = (rstate == R_IDLE) ? araddr  : r_addr;
    assign ra_len   = (rstate == R_IDLE) ? arlen   : ar_len;
    assign ra_size  = (rstate == R_IDLE) ? arsize  : ar_size;
    assign ra_burst = (rstate == R_IDLE) ? arburst : ar_burst;

    axi4_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) u_raddr (
        .addr(ra_addr), .len(ra_len), .size(ra_size), .burst(ra_burst),
        .next_addr(r_next), .base_addr(r_base), .lane_mask(r_mask),
        .legal(r_legal), .out_of_range(r_oob)
    );

    always_comb begin
        rd_beat = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (r_mask[i] && ((r_base + ADDR_W'(i)) < ADDR_W'(MEM_BYTES)))
                rd_beat[8*i +: 8] = mem[MI'(r_base + ADDR_W'(i))];
        end
    end

    always_comb begin
        rstate_n = rstate;
        arready  = 1'b0;
        r_first  = 1'b0;
        r_load   = 1'b0;
        r_done   = 1'b0;
        case (rstate)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    r_first  = 1'b1;
                    rstate_n = R_DATA;
                end
            end
            R_DATA: begin
                if (p_valid && p_ready) begin
                    if (p_last) begin
                        r_done   = 1'b1;
                        rstate_n = R_IDLE;
                    end else begin
                        r_load = 1'b1;
                    end
                end
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arst) begin
            rstate   <= R_IDLE;
            ar_id    <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
            r_addr   <= '0;
            r_idx    <= '0;
            p_valid  <= 1'b0;
            p_last   <= 1'b0;
            p_id     <= '0;
            p_data   <= '0;
            p_resp   <= OKAY;
        end else begin
            rstate <= rstate_n;
            if (r_first || r_load) begin
                p_valid <= 1'b1;
                p_data  <= (r_legal && !r_oob) ? rd_beat : '0;
                p_resp  <= (r_legal && !r_oob) ? OKAY : SLVERR;
                r_addr  <= r_next;
            end
            if (r_first) begin
                ar_id    <= arid;
                ar_len   <= arlen;
                ar_size  <= arsize;
                ar_burst <= arburst;
                p_id     <= arid;
                r_idx    <= '0;
                p_last   <= (arlen == 8'd0);
            end else if (r_load) begin
                r_idx  <= r_idx + 8'd1;
                p_last <= ((r_idx + 8'd1) == ar_len);
            end else if (r_done) begin
                p_valid <= 1'b0;
                p_last  <= 1'b0;
            end
        end
    end

`ifdef AXI4_MEM_RD_PIPE_EN
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } rbeat_t;

    rbeat_t     skid [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] cnt;
    logic       push, pop;

    assign pop     = (cnt != 2'd0) && rready;
    assign p_ready = (cnt != 2'd2) || rready;
    assign push    = p_valid && p_ready;

    always_ff @(posedge aclk) begin
        if (!arst) begin
            skid[0] <= '0;
            skid[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            cnt     <= '0;
        end else begin
            if (push) begin
                skid[wr_ptr] <= '{id: p_id, data: p_data, resp: p_resp, last: p_last};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

    assign rvalid = (cnt != 2'd0);
    assign rid    = skid[rd_ptr].id;
    assign rdata  = skid[rd_ptr].data;
    assign rresp  = skid[rd_ptr].resp;
    assign rlast  = skid[rd_ptr].last;
`else
    assign p_ready = rready;
    assign rvalid  = p_valid;
    assign rid     = p_id;
    assign rdata   = p_data;
    assign rresp   = p_resp;
    assign rlast   = p_last;
`endif

endmodule
